booth_result_serializer: RTL and testbench

Downstream stage of the 384x384 sequential Booth multiplier. Captures each 768-bit product when the multiplier signals completion and streams it out as fixed-width words over a valid/ready interface. Holds one product in a pending buffer, so a new product can be captured while the previous one is still draining. The multiplier cannot be stalled, so a product that arrives with no free buffer is dropped and flagged.

---
 rtl/booth_result_serializer.sv | 139 +++++++++++++
 tb/tb_booth_result_serializer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_result_serializer.sv
// Product serializer: streams each PROD_W product as WORD_W words, LSW first (MSW first under BOOTH_SER_MSB_FIRST_EN).
// Word 0 appears 1 cycle after accept; out_ready low holds the word; a product arriving with the pending buffer full is dropped and sets ovf.
module booth_result_serializer #(
   parameter int PROD_W = 768,
   parameter int WORD_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [PROD_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_last,
   output logic              ovf
);

   localparam int NWORDS = PROD_W / WORD_W;
   localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [PROD_W-1:0] sr_q, sr_d;
   logic [PROD_W-1:0] pb_q, pb_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              pend_full_q, pend_full_d;
   logic              ovf_q, ovf_d;

   logic              accept;
   logic              word_xfer;
   logic              last_xfer;
   logic [PROD_W-1:0] sr_shifted;

   assign accept    = in_valid && in_ready;
   assign word_xfer = out_valid && out_ready;
   assign last_xfer = word_xfer && (idx_q == LAST_IDX);

`ifdef BOOTH_SER_MSB_FIRST_EN
   assign sr_shifted = sr_q << WORD_W;
   assign out_data   = sr_q[PROD_W-1 -: WORD_W];
`else
   assign sr_shifted = sr_q >> WORD_W;
   assign out_data   = sr_q[WORD_W-1:0];
`endif

   // FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (last_xfer && !pend_full_q && !accept) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs; in_ready comes only from registered state
   always_comb begin
      out_valid = (state_q == ST_SEND);
      out_last  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
      in_ready  = !pend_full_q;
      ovf       = ovf_q;
   end

   always_comb begin
      sr_d        = sr_q;
      pb_d        = pb_q;
      idx_d       = idx_q;
      pend_full_d = pend_full_q;
      ovf_d       = ovf_q | (in_valid & ~in_ready);

      if (state_q == ST_IDLE) begin
         if (accept) begin
            sr_d  = in_data;
            idx_d = '0;
         end
      end else begin
         if (last_xfer) begin
            idx_d = '0;
            if (pend_full_q) begin
               sr_d        = pb_q;
               pend_full_d = 1'b0;
            end else if (accept) begin
               // Empty buffer on the final word: load straight into SR, no bubble.
               sr_d = in_data;
            end else begin
               sr_d = '0;
            end
         end else if (word_xfer) begin
            sr_d  = sr_shifted;
            idx_d = idx_q + 1'b1;
         end

         if (accept && !last_xfer) begin
            pb_d        = in_data;
            pend_full_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q        <= '0;
         pb_q        <= '0;
         idx_q       <= '0;
         pend_full_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         sr_q        <= sr_d;
         pb_q        <= pb_d;
         idx_q       <= idx_d;
         pend_full_q <= pend_full_d;
         ovf_q       <= ovf_d;
      end
   end

endmodule

// File: tb/tb_booth_result_serializer.sv
// Bench for booth_result_serializer: directed table, hand-written corner sequences and a random run
// checked every cycle against a product-queue reference model.
module tb_booth_result_serializer;

   localparam int PW = 768;
   localparam int WW = 64;
   localparam int NW = PW / WW;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [PW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [WW-1:0] out_data;
   logic          out_last;
   logic          ovf;

   int nvec = 0;
   int nerr = 0;

   booth_result_serializer #(.PROD_W(PW), .WORD_W(WW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .ovf       (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkw(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // k-th word in transmit order
   function automatic logic [WW-1:0] word_of(input logic [PW-1:0] p, input int k);
      int j;
`ifdef BOOTH_SER_MSB_FIRST_EN
      j = NW - 1 - k;
`else
      j = k;
`endif
      return p[j*WW +: WW];
   endfunction

   function automatic logic [PW-1:0] rand_prod();
      logic [PW-1:0] p;
      for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
      return p;
   endfunction

   // Reference model: queue of products held, word position within the head product.
   logic [PW-1:0] prod_q[$];
   int            widx;
   logic          exp_ovf;
   logic          exp_rdy;

   always @(negedge clk) begin
      if (!rst) begin
         prod_q.delete();
         widx    = 0;
         exp_ovf = 1'b0;
      end else begin
         exp_rdy = (prod_q.size() < 2);
         chk1("m_in_ready", in_ready, exp_rdy);
         chk1("m_out_valid", out_valid, prod_q.size() > 0);
         chk1("m_ovf", ovf, exp_ovf);
         if (prod_q.size() > 0) begin
            chkw("m_out_data", out_data, word_of(prod_q[0], widx));
            chk1("m_out_last", out_last, widx == NW - 1);
         end
         if (out_ready && prod_q.size() > 0) begin
            widx++;
            if (widx == NW) begin
               void'(prod_q.pop_front());
               widx = 0;
            end
         end
         if (in_valid) begin
            if (exp_rdy) prod_q.push_back(in_data);
            else exp_ovf = 1'b1;
         end
      end
   end

   typedef struct {
      logic          in_valid;
      logic          out_ready;
      logic          exp_valid;
      logic          exp_last;
      logic          exp_ready;
      logic [WW-1:0] exp_data;
   } vec_t;

   vec_t tbl[NW + 2];

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [PW-1:0] p);
      in_data  = p;
      in_valid = 1'b1;
      cyc(1);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      out_ready = 1'b1;
      n = 0;
      while ((out_valid || prod_q.size() > 0) && n < 100) begin
         cyc(1);
         n++;
      end
      chk1(nm, out_valid, 1'b0);
   endtask

   logic [PW-1:0] p_a5;
   logic [PW-1:0] p1, p2, p3;
   logic [WW-1:0] base;

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      base      = 64'hA5A5_0000_0000_0000;
      for (int i = 0; i < NW; i++) p_a5[i*WW +: WW] = base + 64'(i);

      // Reset values while held in reset
      cyc(2);
      chk1("rst_out_valid", out_valid, 1'b0);
      chkw("rst_out_data", out_data, '0);
      chk1("rst_out_last", out_last, 1'b0);
      chk1("rst_ovf", ovf, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b1);
      rst = 1'b1;
      cyc(1);

      // Single product, out_ready=1: table of per-cycle expectations
      tbl[0] = '{in_valid: 1'b1, out_ready: 1'b1, exp_valid: 1'b0, exp_last: 1'b0,
                 exp_ready: 1'b1, exp_data: '0};
      for (int k = 1; k <= NW; k++) begin
         tbl[k].in_valid  = 1'b0;
         tbl[k].out_ready = 1'b1;
         tbl[k].exp_valid = 1'b1;
         tbl[k].exp_last  = (k == NW);
         tbl[k].exp_ready = 1'b1;
`ifdef BOOTH_SER_MSB_FIRST_EN
         tbl[k].exp_data  = base + 64'(NW - k);
`else
         tbl[k].exp_data  = base + 64'(k - 1);
`endif
      end
      tbl[NW+1] = '{in_valid: 1'b0, out_ready: 1'b1, exp_valid: 1'b0, exp_last: 1'b0,
                    exp_ready: 1'b1, exp_data: '0};

      in_data = p_a5;
      for (int r = 0; r < NW + 2; r++) begin
         in_valid  = tbl[r].in_valid;
         out_ready = tbl[r].out_ready;
         chk1("tbl_out_valid", out_valid, tbl[r].exp_valid);
         chk1("tbl_out_last", out_last, tbl[r].exp_last);
         chk1("tbl_in_ready", in_ready, tbl[r].exp_ready);
         if (tbl[r].exp_valid) chkw("tbl_out_data", out_data, tbl[r].exp_data);
         cyc(1);
      end
      in_valid = 1'b0;

      // Backpressure: out_ready 1,0,0 repeating; model checks stability and order
      p1 = rand_prod();
      out_ready = 1'b1;
      send(p1);
      for (int i = 0; i < 3 * NW + 6; i++) begin
         out_ready = (i % 3 == 0);
         cyc(1);
      end
      drain("bp_drain");

      // Back-to-back: P2 arrives 3 cycles after P1
      p1 = rand_prod();
      p2 = rand_prod();
      out_ready = 1'b1;
      send(p1);
      cyc(2);
      send(p2);
      chk1("b2b_in_ready_low", in_ready, 1'b0);
      drain("b2b_drain");

      // Overflow: P1 sending, P2 pending, stalled, P3 dropped
      p1 = rand_prod();
      p2 = rand_prod();
      p3 = rand_prod();
      out_ready = 1'b0;
      send(p1);
      send(p2);
      cyc(2);
      send(p3);
      chk1("ovf_set", ovf, 1'b1);
      cyc(3);
      drain("ovf_drain");
      chk1("ovf_sticky", ovf, 1'b1);

      // Asynchronous reset at word 5 of a product
      p1 = rand_prod();
      out_ready = 1'b1;
      send(p1);
      cyc(5);
      chkw("pre_rst_word5", out_data, word_of(p1, 5));
      rst = 1'b0;
      #1;
      chk1("arst_out_valid", out_valid, 1'b0);
      chkw("arst_out_data", out_data, '0);
      chk1("arst_out_last", out_last, 1'b0);
      chk1("arst_ovf", ovf, 1'b0);
      chk1("arst_in_ready", in_ready, 1'b1);
      cyc(2);
      rst = 1'b1;
      cyc(1);
      p1 = rand_prod();
      send(p1);
      chkw("p4_word0", out_data, word_of(p1, 0));
      drain("p4_drain");

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 5) == 0);
         in_data   = rand_prod();
         out_ready = ($urandom_range(0, 3) != 0);
         cyc(1);
      end
      in_valid = 1'b0;
      drain("rand_drain");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
